// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative write-back / write-allocate L2 cache.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   L1 request handshake; req_write, req_addr, req_wdata
//   resp_valid            one-cycle response strobe
//   resp_hit, resp_block  hit flag and full line after the access (held between strobes)
//   mem_addr              block-aligned memory address
//   mem_rd, mem_wr        block read / write-back requests, held until mem_ready
//   mem_wblock            victim line being written back
//   mem_rblock            refill line from memory
//   mem_ready             memory completes the current rd/wr when sampled high
//
// Every L1 access answers with the whole block. Dirty victims are written back
// as full blocks before the refill. Replacement is true LRU, kept as a
// per-way age (0 = most recent, NUM_WAYS-1 = least recent).

// Tag comparator for one way.
module l2_way_match #(
  parameter int TAG_W = 8
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] way_tag,
  input  logic [TAG_W-1:0] req_tag,
  output logic             hit
);
  assign hit = valid && (way_tag == req_tag);
endmodule

module l2_cache_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int CACHE_SIZE = 1024,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_WAYS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [BLOCK_SIZE*8-1:0] resp_block,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [BLOCK_SIZE*8-1:0] mem_wblock,
  input  logic [BLOCK_SIZE*8-1:0] mem_rblock,
  input  logic                    mem_ready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SETS  = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int OFF   = $clog2(BLOCK_SIZE);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = ADDR_WIDTH - IDX - OFF;
  localparam int BW    = BLOCK_SIZE * 8;
  localparam int BOFF  = $clog2(BYTES);
  localparam int AW    = $clog2(NUM_WAYS);

  // HIT is a one-cycle stage between the tag compare and the strobe; DONE
  // keeps req_ready low for the strobe cycle itself.
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_HIT, S_WB, S_FILL, S_DONE} state_t;
  state_t state, state_d;

  // Line storage
  logic [NUM_WAYS-1:0] valid_mem [SETS];
  logic [NUM_WAYS-1:0] dirty_mem [SETS];
  logic [AW-1:0]       age_mem   [SETS][NUM_WAYS];
  logic [TAG-1:0]      tag_mem   [SETS][NUM_WAYS];
  logic [BW-1:0]       data_mem  [SETS][NUM_WAYS];

  // Latched request and working registers
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AW-1:0]         vict_q, vict_d;
  logic [BW-1:0]         line_q, line_d;

  // Next values of the registered outputs
  logic                  req_ready_d, resp_valid_d, resp_hit_d, mem_rd_d, mem_wr_d;
  logic [BW-1:0]         resp_block_d, mem_wblock_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  logic [TAG-1:0]       tag_q;
  logic [IDX-1:0]       idx_q;
  logic [OFF-BOFF-1:0]  word_q;
  logic                 unused_addr_bits;
  assign tag_q  = addr_q[ADDR_WIDTH-1 -: TAG];
  assign idx_q  = addr_q[OFF +: IDX];
  assign word_q = addr_q[OFF-1:BOFF];
  assign unused_addr_bits = ^addr_q[BOFF-1:0];  // writes are whole-word

  logic [NUM_WAYS-1:0] hit_vec;
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    l2_way_match #(.TAG_W(TAG)) u_match (
      .valid   (valid_mem[idx_q][w]),
      .way_tag (tag_mem[idx_q][w]),
      .req_tag (tag_q),
      .hit     (hit_vec[w])
    );
  end

  logic          hit, inv_found;
  logic [AW-1:0] hit_way, inv_way, old_way, victim, acc_way, acc_age;
  assign hit    = |hit_vec;
  assign victim = inv_found ? inv_way : old_way;

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = AW'(w);
      if (!valid_mem[idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = AW'(w);
      end
      if (age_mem[idx_q][w] == AW'(NUM_WAYS-1)) old_way = AW'(w);
    end
  end

  // Line after the access: stored/refilled line with the write word merged in.
  logic [BW-1:0] hit_line, fill_line;
  always_comb begin
    hit_line  = data_mem[idx_q][hit_way];
    fill_line = mem_rblock;
    if (write_q) begin
      hit_line[int'(word_q)*DATA_WIDTH +: DATA_WIDTH]  = wdata_q;
      fill_line[int'(word_q)*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
    end
  end

  logic lookup_hit, wb_done, fill_done;
  assign lookup_hit = (state == S_LOOKUP) && hit;
  assign wb_done    = (state == S_WB) && mem_ready;
  assign fill_done  = (state == S_FILL) && mem_ready;

  // LRU: ways younger than the accessed one age by one; accessed way -> 0.
  logic [NUM_WAYS-1:0][AW-1:0] age_upd;
  assign acc_way = (state == S_FILL) ? vict_q : hit_way;
  assign acc_age = age_mem[idx_q][acc_way];
  always_comb begin
    age_upd = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (AW'(w) == acc_way)              age_upd[w] = '0;
      else if (age_mem[idx_q][w] < acc_age) age_upd[w] = age_mem[idx_q][w] + 1'b1;
      else                                  age_upd[w] = age_mem[idx_q][w];
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state;
    req_ready_d  = req_ready;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit;
    resp_block_d = resp_block;
    mem_addr_d   = mem_addr;
    mem_rd_d     = mem_rd;
    mem_wr_d     = mem_wr;
    mem_wblock_d = mem_wblock;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    vict_d       = vict_q;
    line_d       = line_q;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d      = req_addr;
          write_d     = req_write;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          state_d     = S_LOOKUP;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          line_d  = hit_line;
          state_d = S_HIT;
        end else begin
          vict_d = victim;
          if (valid_mem[idx_q][victim] && dirty_mem[idx_q][victim]) begin
            mem_wr_d     = 1'b1;
            mem_addr_d   = {tag_mem[idx_q][victim], idx_q, {OFF{1'b0}}};
            mem_wblock_d = data_mem[idx_q][victim];
            state_d      = S_WB;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = {tag_q, idx_q, {OFF{1'b0}}};
            state_d    = S_FILL;
          end
        end
      end
      S_HIT: begin
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b1;
        resp_block_d = line_q;
        state_d      = S_DONE;
      end
      S_WB: begin
        if (mem_ready) begin
          mem_wr_d   = 1'b0;
          mem_rd_d   = 1'b1;
          mem_addr_d = {tag_q, idx_q, {OFF{1'b0}}};
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          mem_rd_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_block_d = fill_line;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_block <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wblock <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      vict_q     <= '0;
      line_q     <= '0;
    end else begin
      state      <= state_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_hit   <= resp_hit_d;
      resp_block <= resp_block_d;
      mem_addr   <= mem_addr_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_wblock <= mem_wblock_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      vict_q     <= vict_d;
      line_q     <= line_d;
    end
  end

  // Line state bits: cleared by reset; ages start as the identity permutation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_mem[s][w] <= AW'(w);
      end
    end else begin
      if (lookup_hit && write_q) dirty_mem[idx_q][hit_way] <= 1'b1;
      if (wb_done) dirty_mem[idx_q][vict_q] <= 1'b0;
      if (fill_done) begin
        valid_mem[idx_q][vict_q] <= 1'b1;
        dirty_mem[idx_q][vict_q] <= write_q;
      end
      if (lookup_hit || fill_done)
        for (int w = 0; w < NUM_WAYS; w++) age_mem[idx_q][w] <= age_upd[w];
    end
  end

  // Tag and data payload need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (lookup_hit && write_q) data_mem[idx_q][hit_way] <= hit_line;
    if (fill_done) begin
      tag_mem[idx_q][vict_q]  <= tag_q;
      data_mem[idx_q][vict_q] <= fill_line;
    end
  end
endmodule

// File: tb/tb_l2_cache_wb.sv
module tb_l2_cache_wb;
  localparam int BW   = 256;
  localparam int BLK  = 32;
  localparam int SETS = 8;
  localparam int NW   = 4;
  localparam int WPB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [15:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, resp_valid, resp_hit, mem_rd, mem_wr;
  logic [BW-1:0] resp_block, mem_wblock;
  logic [BW-1:0] mem_rblock = '0;
  logic [15:0]   mem_addr;
  logic          mem_ready = 1'b0;

  l2_cache_wb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_block(resp_block),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wblock(mem_wblock),
    .mem_rblock(mem_rblock), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- main memory + responder ----------------
  logic [BW-1:0] mem_img [2048];
  typedef struct { bit wr; logic [15:0] addr; logic [BW-1:0] blk; } ev_t;
  ev_t ev_q[$];
  int  lat_cnt = 0, lat_target = 3;
  bit  rand_lat = 0, have_prev = 0, overlap_seen = 0, unstable_seen = 0;
  logic [15:0]   prev_addr;
  logic [BW-1:0] prev_blk;

  always @(negedge clk) begin
    ev_t ev;
    mem_ready = 1'b0;
    if (!rst_n) begin
      lat_cnt = 0;
      have_prev = 0;
    end else if (mem_rd || mem_wr) begin
      if (mem_rd && mem_wr) overlap_seen = 1;
      if (have_prev && (mem_addr != prev_addr || (mem_wr && mem_wblock != prev_blk))) unstable_seen = 1;
      prev_addr = mem_addr;
      prev_blk  = mem_wblock;
      have_prev = 1;
      lat_cnt++;
      if (lat_cnt >= lat_target) begin
        mem_ready = 1'b1;
        lat_cnt = 0;
        have_prev = 0;
        ev.wr = mem_wr; ev.addr = mem_addr; ev.blk = mem_wr ? mem_wblock : '0;
        ev_q.push_back(ev);
        if (mem_wr) mem_img[mem_addr[15:5]] = mem_wblock;
        else        mem_rblock = mem_img[mem_addr[15:5]];
        lat_target = rand_lat ? int'($urandom_range(1, 4)) : 3;
      end
    end else begin
      lat_cnt = 0;
      have_prev = 0;
    end
  end

  // ---------------- reference model: recency-stamped lines per set ----------------
  bit            m_valid [SETS][NW];
  bit            m_dirty [SETS][NW];
  int            m_tag   [SETS][NW];
  longint        m_stamp [SETS][NW];
  logic [BW-1:0] m_data  [SETS][NW];
  longint        m_now = 0;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_stamp[s][w] = 0;
      end
  endtask

  task automatic model_access(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                              output bit hit, output logic [BW-1:0] blk,
                              output bit wb, output logic [15:0] wba, output logic [BW-1:0] wbblk);
    int s, t, wi, way;
    longint best;
    s = (int'(a) / BLK) % SETS;
    t = int'(a) / (BLK * SETS);
    wi = (int'(a) / 4) % WPB;
    hit = 0; wb = 0; wba = '0; wbblk = '0; way = 0;
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
    if (!hit) begin
      way = -1;
      for (int w = NW-1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) begin
        best = 64'h7fffffffffffffff;
        for (int w = 0; w < NW; w++)
          if (m_stamp[s][w] < best) begin best = m_stamp[s][w]; way = w; end
      end
      if (m_valid[s][way] && m_dirty[s][way]) begin
        wb = 1;
        wba = 16'((m_tag[s][way] * SETS + s) * BLK);
        wbblk = m_data[s][way];
      end
      m_valid[s][way] = 1;
      m_tag[s][way] = t;
      m_dirty[s][way] = 0;
      m_data[s][way] = mem_img[int'(a) / BLK];
    end
    if (wr) begin
      m_data[s][way][wi*32 +: 32] = wd;
      m_dirty[s][way] = 1;
    end
    m_now++;
    m_stamp[s][way] = m_now;
    blk = m_data[s][way];
  endtask

  // ---------------- request driver ----------------
  task automatic do_req(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                        output bit hit, output logic [BW-1:0] blk, output int lat, output bit tmo);
    int n;
    n = 0; tmo = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) tmo = 1;
    ev_q.delete();
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) tmo = 1;
    hit = resp_hit;
    blk = resp_block;
  endtask

  task automatic run_req(input string nm, input bit wr, input logic [15:0] a, input logic [31:0] wd,
                         output bit g_hit, output logic [BW-1:0] g_blk);
    bit e_hit, e_wb, tmo;
    logic [BW-1:0] e_blk, e_wbblk;
    logic [15:0] e_wba;
    int lat, n_ev;
    model_access(wr, a, wd, e_hit, e_blk, e_wb, e_wba, e_wbblk);
    do_req(wr, a, wd, g_hit, g_blk, lat, tmo);
    check({nm, "_timeout"}, BW'(tmo), '0);
    check({nm, "_hit"}, BW'(g_hit), BW'(e_hit));
    check({nm, "_block"}, g_blk, e_blk);
    if (e_hit) check({nm, "_hit_latency"}, BW'(lat), BW'(2));
    n_ev = e_hit ? 0 : (e_wb ? 2 : 1);
    check({nm, "_mem_events"}, BW'(ev_q.size()), BW'(n_ev));
    if (ev_q.size() == n_ev && e_wb) begin
      check({nm, "_wb_is_write"}, BW'(ev_q[0].wr), BW'(1));
      check({nm, "_wb_addr"}, BW'(ev_q[0].addr), BW'(e_wba));
      check({nm, "_wb_block"}, ev_q[0].blk, e_wbblk);
    end
    if (ev_q.size() == n_ev && n_ev > 0) begin
      check({nm, "_fill_is_read"}, BW'(ev_q[n_ev-1].wr), BW'(0));
      check({nm, "_fill_addr"}, BW'(ev_q[n_ev-1].addr), BW'(a & 16'hFFE0));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit wr; logic [15:0] addr; logic [31:0] wdata; bit exp_hit;
    int chk_word; logic [31:0] exp_word; bit exp_wb; logic [15:0] wb_addr; logic [31:0] wb_w0;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(bit wr, logic [15:0] a, logic [31:0] wd, bit h, int cw, logic [31:0] ew,
                              bit wb, logic [15:0] wba, logic [31:0] w0);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_hit = h; v.chk_word = cw; v.exp_word = ew;
    v.exp_wb = wb; v.wb_addr = wba; v.wb_w0 = w0;
    return v;
  endfunction

  initial begin
    bit g_hit;
    logic [BW-1:0] g_blk;
    logic [15:0] ra;
    int n;

    for (int b = 0; b < 2048; b++)
      for (int i = 0; i < WPB; i++)
        mem_img[b][i*32 +: 32] = (b == 2) ? 32'h1000 + i : {16'(b * BLK), 16'(i)};
    model_reset();

    vq.push_back(mk(0, 16'h0040, 32'h0,        0, 0, 32'h0000_1000, 0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0044, 32'h0,        1, 1, 32'h0000_1001, 0, 16'h0,    32'h0));
    vq.push_back(mk(1, 16'h0048, 32'hDEADBEEF, 1, 2, 32'hDEADBEEF,  0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0040, 32'h0,        1, 2, 32'hDEADBEEF,  0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h004C, 32'h0,        1, 3, 32'h0000_1003, 0, 16'h0,    32'h0));
    vq.push_back(mk(1, 16'h0140, 32'h55AA55AA, 0, 0, 32'h55AA55AA,  0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0240, 32'h0,        0, 0, 32'h0240_0000, 0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0340, 32'h0,        0, 0, 32'h0340_0000, 0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0040, 32'h0,        1, 2, 32'hDEADBEEF,  0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0440, 32'h0,        0, 0, 32'h0440_0000, 1, 16'h0140, 32'h55AA55AA));
    vq.push_back(mk(0, 16'h0040, 32'h0,        1, 0, 32'h0000_1000, 0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0140, 32'h0,        0, 0, 32'h55AA55AA,  0, 16'h0,    32'h0));
    vq.push_back(mk(1, 16'h0800, 32'h12345678, 0, 0, 32'h12345678,  0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h0C00, 32'h0,        0, 0, 32'h0C00_0000, 0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h1000, 32'h0,        0, 0, 32'h1000_0000, 0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h1400, 32'h0,        0, 0, 32'h1400_0000, 0, 16'h0,    32'h0));
    vq.push_back(mk(0, 16'h1800, 32'h0,        0, 0, 32'h1800_0000, 1, 16'h0800, 32'h12345678));

    // Reset state
    #3;
    check("reset_ctrl_outputs", BW'({req_ready, resp_valid, resp_hit, mem_rd, mem_wr, mem_addr}), '0);
    check("reset_resp_block", resp_block, '0);
    check("reset_mem_wblock", mem_wblock, '0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", BW'(req_ready), BW'(1));

    foreach (vq[i]) begin
      run_req($sformatf("v%0d", i), vq[i].wr, vq[i].addr, vq[i].wdata, g_hit, g_blk);
      check($sformatf("v%0d_table_hit", i), BW'(g_hit), BW'(vq[i].exp_hit));
      check($sformatf("v%0d_table_word", i), BW'(g_blk[vq[i].chk_word*32 +: 32]), BW'(vq[i].exp_word));
      if (vq[i].exp_wb) begin
        check($sformatf("v%0d_table_wb_seen", i), BW'(ev_q.size() > 0 && ev_q[0].wr), BW'(1));
        if (ev_q.size() > 0) begin
          check($sformatf("v%0d_table_wb_addr", i), BW'(ev_q[0].addr), BW'(vq[i].wb_addr));
          check($sformatf("v%0d_table_wb_w0", i), BW'(ev_q[0].blk[31:0]), BW'(vq[i].wb_w0));
        end
      end
    end

    // Reset while a refill is outstanding
    ev_q.delete();
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1; req_write = 0; req_addr = 16'h2000;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!mem_rd && n < 50) begin @(posedge clk); #1; n++; end
    check("midfill_rd_seen", BW'(mem_rd), BW'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midfill_reset_ctrl", BW'({req_ready, resp_valid, resp_hit, mem_rd, mem_wr, mem_addr}), '0);
    check("midfill_reset_block", resp_block, '0);
    model_reset();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midfill_ready_after", BW'(req_ready), BW'(1));
    run_req("post_reset_read", 0, 16'h2000, 32'h0, g_hit, g_blk);

    // Randomised traffic: six tags over four ways forces evictions
    rand_lat = 1;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom_range(0, 5) * 256 + $urandom_range(0, 7) * 32 + $urandom_range(0, 31));
      run_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), ra, $urandom, g_hit, g_blk);
    end

    check("rd_wr_overlap", BW'(overlap_seen), '0);
    check("mem_req_stable", BW'(unstable_seen), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/l2_cache_wb.md
Name: l2_cache_wb

Overview:
Parametrised set-associative L2 cache between the L1 cache and main memory. It uses write-back and write-allocate policies, with per-line dirty bits and true-LRU replacement.
It serves L1 word reads and writes over a valid/ready request channel and returns the whole block on every response. Dirty victims are written back to memory as full blocks before each refill.

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8)
ADDR_WIDTH, 16, byte address width
CACHE_SIZE, 1024, capacity in bytes
BLOCK_SIZE, 32, line size in bytes
NUM_WAYS, 4, associativity (power of two, >=2)
Derived: WPB=BLOCK_SIZE/(DATA_WIDTH/8); SETS=CACHE_SIZE/BLOCK_SIZE/NUM_WAYS; OFF=clog2(BLOCK_SIZE); IDX=clog2(SETS); TAG=ADDR_WIDTH-IDX-OFF; BW=DATA_WIDTH*WPB

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  L1 request present
req_ready  out  1  cache can accept a request
req_write  in  1  1=word write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write word
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  1=request hit, 0=serviced by refill
resp_block  out  BW  full line after the access; word i at [i*DATA_WIDTH +: DATA_WIDTH]
mem_addr  out  ADDR_WIDTH  block-aligned memory address
mem_rd  out  1  block read request
mem_wr  out  1  block write request
mem_wblock  out  BW  victim line for write-back
mem_rblock  in  BW  refill line; same packing as resp_block
mem_ready  in  1  memory completes the current rd/wr on the cycle it is sampled high

Behaviour:
- Address fields: tag=addr[ADDR_WIDTH-1:IDX+OFF], index=addr[IDX+OFF-1:OFF], word=addr[OFF-1:clog2(DATA_WIDTH/8)]. Byte bits are ignored; writes are whole-word.
- Storage per set and way: tag, data[WPB], valid, dirty, and an age counter of clog2(NUM_WAYS) bits.
- Reset (async): all outputs go to 0, all valid and dirty bits clear, age of way w = w, state = IDLE.
  - A reset mid-operation aborts the transaction; mem_rd and mem_wr drop immediately, and any pending dirty data is lost.
- All outputs are registered.
- IDLE:
  - req_ready=1, starting the cycle after reset release.
  - On req_valid&&req_ready, latch addr, write and wdata; req_ready goes 0; next state LOOKUP.
- LOOKUP: compare the tag against all valid ways of the set.
  - Hit on way k:
    - Write: merge wdata into word; dirty[k]=1.
    - Update LRU.
    - resp_valid=1 and resp_hit=1 next cycle, with resp_block = updated line.
    - Next state IDLE.
  - Hit latency: request accepted at edge N, resp_valid high in cycle after edge N+2.
  - Miss:
    - Victim = lowest-index invalid way; if none, the way with age NUM_WAYS-1.
    - Victim valid&&dirty goes to WRITEBACK, otherwise to FILL.
- WRITEBACK:
  - mem_wr=1, mem_addr={victim tag, index, 0}, mem_wblock=victim line. These are held stable until mem_ready.
  - On mem_ready: mem_wr drops next cycle; victim dirty=0; next state FILL.
- FILL:
  - mem_rd=1, mem_addr={req tag, index, 0}, held until mem_ready.
  - On mem_ready, install mem_rblock into the victim way:
    - tag and valid=1.
    - Write request: merge wdata into the word, dirty=1; read request: dirty=0.
  - Update LRU.
  - resp_valid=1, resp_hit=0, resp_block = installed line.
  - Next state IDLE.
- mem_rd and mem_wr are never high together. mem_ready is ignored outside WRITEBACK and FILL.
- LRU update on access to way k with age a: every way in the set with age<a increments, and way k becomes 0. Ages stay a permutation of 0..NUM_WAYS-1.
- resp_block and resp_hit hold their value between strobes; resp_valid is a single cycle.
- Only one request is outstanding at a time; req_ready stays 0 from accept until the cycle after resp_valid.

Test Plan:
1. Cold read miss 0x0040 (set 2), mem_ready 3 cycles after mem_rd with word i = 0x1000+i -> mem_rd with mem_addr=0x0040, resp_hit=0, block words 0x1000..0x1007. Then read 0x0044 -> resp_hit=1, resp_valid 2 cycles after accept, no mem_rd.
2. Write hit 0x0048 data 0xDEADBEEF after test 1 -> resp_hit=1, word2=0xDEADBEEF. Read 0x0040 -> word2=0xDEADBEEF, other words unchanged.
3. LRU: fill set 2 with 0x0040, 0x0140, 0x0240, 0x0340, re-read 0x0040, then miss on 0x0440 -> victim is the 0x0140 line; 0x0040 still hits afterwards.
4. Dirty eviction: line 0x0140 written 0x55AA55AA then evicted -> mem_wr with mem_addr=0x0140 and mem_wblock word0=0x55AA55AA, then mem_rd of the new block, mem_wr and mem_rd never overlapping.
5. Write miss 0x0800 data 0x12345678 -> FILL, resp_hit=0, word0=0x12345678. A later eviction of that line writes it back with word0=0x12345678.
6. rst_n low while mem_rd=1 in FILL -> mem_rd=0 immediately, all outputs 0. After release, req_ready=1 and a read of the same address misses.
